uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- Parametrised UART receiver that extends the single-rate 8-bit receiver.
- Adds baud oversampling, mid-bit sampling with false-start rejection, and configurable data width, parity mode and stop bits.
- Adds a parametrised receive FIFO and sticky error flags: parity, framing, overrun, break.
- Sits between the board rx pin and the consumer logic, using the team's sent/recieved handshake.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, sent LSB first.
- PARITY, 1: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- CLKS_PER_BIT, 16: clk cycles per bit period, even, at least 4.
- FIFO_DEPTH, 4: FIFO entries, a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line, idle high.
- data  output  DATA_BITS  FIFO head word, valid while sent=1.
- sent  output  1  high when the FIFO is not empty.
- recieved  input  1  consumer acknowledge; pops the head when sent=1.
- count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- error  output  4  sticky flags: [0] parity, [1] framing, [2] overrun, [3] break.
- clear_error  input  1  clears all error bits.

Behaviour:
- Reset values:
  - data=0, sent=0, count=0, error=0.
  - FSM in IDLE; both synchroniser flops =1; bit and baud counters =0.
  - A reset mid-frame abandons the frame; nothing is pushed.
- Input sync: rx passes through a 2-flop synchroniser; rs is the synchronised value. All FSM decisions use rs.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE:
  - A 1 to 0 transition on rs goes to START.
  - The baud counter loads CLKS_PER_BIT/2-1.
- Sampling cadence:
  - Each state samples rs when the baud counter reaches 0.
  - The counter then reloads CLKS_PER_BIT-1, so samples fall at mid-bit.
- START: sample=1 is a false start and returns to IDLE with no flag change. Sample=0 goes to DATA.
- DATA:
  - DATA_BITS samples are shifted in LSB first.
  - After the last sample, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - Even mode expects ^data_bits; odd mode expects ~^data_bits.
  - A mismatch marks the frame parity-bad.
- STOP:
  - STOP_BITS samples are taken, each required to be 1.
  - Any 0 marks the frame framing-bad.
  - The frame completes on the cycle of the last stop sample; the FSM returns to IDLE the next cycle, i.e. mid stop bit, to catch back-to-back frames.
- Break detection:
  - A break is all data bits 0, the parity bit 0 (if present) and the first stop sample 0.
  - It sets error[3] only; error[0] and error[1] are not set for that frame.
  - Nothing is pushed; go to BREAK_WAIT.
  - BREAK_WAIT stays until rs=1, then goes to IDLE.
- Frame completion:
  - A good frame with the FIFO not full is pushed.
  - A parity-bad frame sets error[0]; a framing-bad frame sets error[1]. Bad frames are never pushed.
  - A good frame with the FIFO full is dropped and sets error[2]; FIFO contents are unchanged.
- FIFO behaviour:
  - First-word-fall-through: data is the head entry; sent=(count!=0).
  - A pop occurs on a cycle with sent&&recieved. The head advances and count decrements, registered.
  - recieved while sent=0 is ignored.
  - Push and pop in the same cycle leave count unchanged. When full, this is legal: the pop frees the slot, so no overrun.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Latency: a word pushed on cycle N has sent=1 and valid data on cycle N+1 when the FIFO was empty.
- Errors:
  - Bits are sticky.
  - clear_error zeroes all bits, except a set event in the same cycle wins for that bit.
  - Error flags do not block reception.

Test Plan:
- Clean frame: DATA_BITS=8, PARITY=1, CLKS_PER_BIT=16. Send 0xA5 (parity bit 0, stop 1) -> sent=1 one cycle after the stop-bit mid-sample; data=8'hA5; count=1; error=0. Pulse recieved -> sent=0, count=0.
- Glitch: rx low for 4 clk then high -> FSM back in IDLE; no push; error=0.
- Parity error: send 0x01 with parity bit 0 -> error=4'b0001, count=0. Pulse clear_error -> error=0.
- Overrun: FIFO_DEPTH=4, send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back with recieved=0 -> count=4, error[2]=1. Four pops yield 0x11, 0x22, 0x33, 0x44 in order.
- Break and simultaneous events:
  - Hold rx low for 12 bit times -> error[3]=1 only; no push. The FSM stays in BREAK_WAIT until rx rises, then a following 0x3C is received correctly.
  - With the FIFO full, a push coinciding with sent&&recieved -> count stays 4 and error[2]=0.
- Reset mid-frame: assert reset during the DATA state of 0x7E -> all outputs 0. After release, a fresh 0x7E frame is received with count=1.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with mid-bit sampling, break detection and sticky errors, feeding a FWFT receive FIFO.
// Latency: a completed frame is visible at the FIFO head one cycle after its last stop sample; full FIFO drops frames (overrun).

// Generic FWFT FIFO: head is visible while rd_vld=1; a push into a full FIFO is accepted only alongside a pop.
// Latency: one cycle from push to rd_vld; wr_rdy deasserts when full unless the same cycle pops.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_vld,
   input  logic [WIDTH-1:0]         wr_dat,
   output logic                     wr_rdy,
   output logic                     rd_vld,
   output logic [WIDTH-1:0]         rd_dat,
   input  logic                     rd_rdy,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign rd_vld = (count != '0);
   assign pop    = rd_vld && rd_rdy;
   assign wr_rdy = (count != FULL_CNT) || pop;
   assign push   = wr_vld && wr_rdy;
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_dat;
   end
endmodule

// UART receiver top: sync -> framing FSM -> FIFO, with sticky error flags {break, overrun, framing, parity}.
// Latency: head valid one cycle after the final stop sample; consumer backpressure only causes overrun drops.
module uart_rx_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 1,
   parameter int STOP_BITS    = 1,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          data,
   output logic                          sent,
   input  logic                          recieved,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic [3:0]                    error,
   input  logic                          clear_error
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int NW = $clog2(DATA_BITS + 1);
   localparam logic [BW-1:0] HALF_LOAD = BW'(CLKS_PER_BIT/2 - 1);
   localparam logic [BW-1:0] FULL_LOAD = BW'(CLKS_PER_BIT - 1);
   localparam logic [NW-1:0] LAST_DATA = NW'(DATA_BITS - 1);
   localparam logic [NW-1:0] LAST_STOP = NW'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK_WAIT
   } state_t;

   state_t                 state, state_nxt;
   logic                   rx_meta, rs, rs_d;
   logic [BW-1:0]          baud_cnt, baud_nxt;
   logic [NW-1:0]          bit_cnt, bit_nxt;
   logic [DATA_BITS-1:0]   shreg, sh_nxt;
   logic                   par_bit, par_bit_nxt;
   logic                   par_bad, par_bad_nxt;
   logic                   frm_bad, frm_bad_nxt;
   logic                   stop_bad;
   logic                   frame_vld;
   logic [3:0]             err_set;
   logic                   tick;
   logic                   par_exp;
   logic                   wr_rdy;
   logic [DATA_BITS-1:0]   fifo_dat;

   assign tick    = (baud_cnt == '0);
   assign par_exp = (PARITY == 2) ? ~^shreg : ^shreg;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta  <= 1'b1;
         rs       <= 1'b1;
         rs_d     <= 1'b1;
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
         par_bad  <= 1'b0;
         frm_bad  <= 1'b0;
         error    <= '0;
      end else begin
         rx_meta  <= rx;
         rs       <= rx_meta;
         rs_d     <= rs;
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= sh_nxt;
         par_bit  <= par_bit_nxt;
         par_bad  <= par_bad_nxt;
         frm_bad  <= frm_bad_nxt;
         error    <= (clear_error ? 4'b0000 : error) | err_set;
      end
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = baud_cnt;
      bit_nxt     = bit_cnt;
      sh_nxt      = shreg;
      par_bit_nxt = par_bit;
      par_bad_nxt = par_bad;
      frm_bad_nxt = frm_bad;
      frame_vld   = 1'b0;
      err_set     = 4'b0000;
      stop_bad    = frm_bad | ~rs;

      if (state != S_IDLE && state != S_BREAK_WAIT)
         baud_nxt = tick ? FULL_LOAD : baud_cnt - 1'b1;

      unique case (state)
         S_IDLE: begin
            if (rs_d && !rs) begin
               state_nxt   = S_START;
               baud_nxt    = HALF_LOAD;
               bit_nxt     = '0;
               par_bit_nxt = 1'b0;
               par_bad_nxt = 1'b0;
               frm_bad_nxt = 1'b0;
            end
         end
         S_START: begin
            if (tick) begin
               state_nxt = rs ? S_IDLE : S_DATA;
               bit_nxt   = '0;
            end
         end
         S_DATA: begin
            if (tick) begin
               sh_nxt = {rs, shreg[DATA_BITS-1:1]};
               if (bit_cnt == LAST_DATA) begin
                  bit_nxt   = '0;
                  state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_nxt = bit_cnt + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               par_bit_nxt = rs;
               par_bad_nxt = (rs != par_exp);
               state_nxt   = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               // An all-zero frame with a low first stop sample is a line break, not a data/framing error.
               if (bit_cnt == '0 && !rs && shreg == '0 && !par_bit) begin
                  state_nxt  = S_BREAK_WAIT;
                  err_set[3] = 1'b1;
               end else if (bit_cnt == LAST_STOP) begin
                  state_nxt  = S_IDLE;
                  err_set[0] = par_bad;
                  err_set[1] = stop_bad;
                  frame_vld  = !par_bad && !stop_bad;
                  err_set[2] = frame_vld && !wr_rdy;
               end else begin
                  frm_bad_nxt = stop_bad;
                  bit_nxt     = bit_cnt + 1'b1;
               end
            end
         end
         S_BREAK_WAIT: begin
            if (rs) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   sync_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (frame_vld),
      .wr_dat (shreg),
      .wr_rdy (wr_rdy),
      .rd_vld (sent),
      .rd_dat (fifo_dat),
      .rd_rdy (recieved),
      .count  (count)
   );

   assign data = sent ? fifo_dat : '0;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: frame vectors plus hand sequences for glitch, overrun, break, full push/pop and reset.
// Expected words go through a scoreboard queue and are compared as the FIFO head is popped.
module tb_uart_rx_fifo;
   localparam int DB    = 8;
   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   // Negedge (counted from driving the start bit) at which a pushed word is first visible:
   // 3 edges of sync + edge detect, half a bit to the start sample, then 10 more bit periods.
   localparam int PUSH_VIS = 3 + CPB/2 + 10*CPB;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx = 1'b1;
   logic          recieved = 1'b0;
   logic          clear_error = 1'b0;
   logic [DB-1:0] data;
   logic          sent;
   logic [CW-1:0] count;
   logic [3:0]    error;

   int checks = 0;
   int errors = 0;
   logic [7:0] sb[$];

   typedef struct {
      logic [7:0] d;
      logic       pbit;
      logic       sbit;
      logic [3:0] exp_err;
      logic       exp_push;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .DATA_BITS(DB), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx), .data(data), .sent(sent),
      .recieved(recieved), .count(count), .error(error), .clear_error(clear_error)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_pulse();
      clear_error = 1'b1;
      step(1);
      clear_error = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                             input int ack_at, input bit chk_lat);
      logic [10:0] bits;
      bits = {sbit, pbit, d, 1'b0};
      for (int cyc = 0; cyc < 11*CPB; cyc++) begin
         if (cyc % CPB == 0) rx = bits[cyc/CPB];
         if (chk_lat && cyc == PUSH_VIS-1) chk("lat_before", 32'(sent), 0);
         if (chk_lat && cyc == PUSH_VIS) begin
            chk("lat_sent", 32'(sent), 1);
            chk("lat_data", 32'(data), 'hA5);
            chk("lat_count", 32'(count), 1);
            chk("lat_error", 32'(error), 0);
         end
         if (cyc == ack_at) begin
            chk("ack_sent", 32'(sent), 1);
            chk("ack_head", 32'(data), 32'(sb.pop_front()));
            recieved = 1'b1;
         end else begin
            recieved = 1'b0;
         end
         @(negedge clk);
      end
      recieved = 1'b0;
      rx = 1'b1;
   endtask

   task automatic send_good(input logic [7:0] d);
      send_frame(d, ^d, 1'b1, -1, 1'b0);
   endtask

   task automatic pop_one(input string name);
      logic [7:0] exp;
      if (sb.size() == 0) begin
         chk({name, "_sb_empty"}, 32'(sent), 0);
      end else begin
         exp = sb.pop_front();
         chk({name, "_sent"}, 32'(sent), 1);
         chk({name, "_data"}, 32'(data), 32'(exp));
         recieved = 1'b1;
         step(1);
         recieved = 1'b0;
      end
   endtask

   initial begin
      vecs[0] = '{8'h5A, 1'b0, 1'b1, 4'b0000, 1'b1};
      vecs[1] = '{8'hFF, 1'b0, 1'b1, 4'b0000, 1'b1};
      vecs[2] = '{8'h07, 1'b1, 1'b1, 4'b0000, 1'b1};
      vecs[3] = '{8'h01, 1'b0, 1'b1, 4'b0001, 1'b0};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 4'b0010, 1'b0};
      vecs[5] = '{8'h03, 1'b1, 1'b0, 4'b0011, 1'b0};
      vecs[6] = '{8'h00, 1'b0, 1'b0, 4'b1000, 1'b0};
      vecs[7] = '{8'h00, 1'b1, 1'b1, 4'b0001, 1'b0};

      step(3);
      chk("rst_data", 32'(data), 0);
      chk("rst_sent", 32'(sent), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_error", 32'(error), 0);
      reset = 1'b0;
      step(5);

      // Clean frame with exact push latency, then pop.
      sb.push_back(8'hA5);
      send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b1);
      step(10);
      pop_one("clean");
      chk("clean_empty_sent", 32'(sent), 0);
      chk("clean_empty_count", 32'(count), 0);
      recieved = 1'b1;
      step(1);
      recieved = 1'b0;
      chk("ack_when_empty", 32'(count), 0);

      // Short low glitch must be rejected as a false start.
      rx = 1'b0;
      step(4);
      rx = 1'b1;
      step(30);
      chk("glitch_count", 32'(count), 0);
      chk("glitch_error", 32'(error), 0);
      sb.push_back(8'h96);
      send_good(8'h96);
      step(10);
      pop_one("after_glitch");

      foreach (vecs[i]) begin
         clear_pulse();
         chk($sformatf("vec%0d_cleared", i), 32'(error), 0);
         if (vecs[i].exp_push) sb.push_back(vecs[i].d);
         send_frame(vecs[i].d, vecs[i].pbit, vecs[i].sbit, -1, 1'b0);
         step(10);
         chk($sformatf("vec%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
         chk($sformatf("vec%0d_count", i), 32'(count), 32'(sb.size()));
         if (vecs[i].exp_push) pop_one($sformatf("vec%0d", i));
      end
      clear_pulse();
      chk("clear_error", 32'(error), 0);

      // Overrun: five back-to-back frames into a depth-4 FIFO, fifth is dropped.
      for (int i = 0; i < 5; i++) begin
         logic [7:0] d;
         d = 8'(8'h11 * (i + 1));
         if (i < DEPTH) sb.push_back(d);
         send_good(d);
      end
      step(10);
      chk("ovr_count", 32'(count), DEPTH);
      chk("ovr_error", 32'(error), 'h4);
      for (int i = 0; i < DEPTH; i++) pop_one($sformatf("ovr_pop%0d", i));
      chk("ovr_drained", 32'(count), 0);
      clear_pulse();

      // Break: line low for 12 bit times, then a normal frame.
      rx = 1'b0;
      step(12*CPB);
      chk("brk_error", 32'(error), 'h8);
      chk("brk_count", 32'(count), 0);
      rx = 1'b1;
      step(20);
      sb.push_back(8'h3C);
      send_good(8'h3C);
      step(10);
      chk("brk_sticky", 32'(error), 'h8);
      pop_one("after_brk");
      clear_pulse();

      // Full FIFO: push lands on the same edge as a pop, so no overrun.
      for (int i = 0; i < DEPTH; i++) begin
         logic [7:0] d;
         d = 8'(8'hA1 + 8'h11 * i);
         sb.push_back(d);
         send_good(d);
      end
      sb.push_back(8'hE5);
      send_frame(8'hE5, ^8'hE5, 1'b1, PUSH_VIS-1, 1'b0);
      step(10);
      chk("simul_count", 32'(count), DEPTH);
      chk("simul_error", 32'(error), 0);
      for (int i = 0; i < DEPTH; i++) pop_one($sformatf("simul_pop%0d", i));
      chk("simul_drained", 32'(count), 0);

      // Reset in the middle of a frame with a stored word and a pending error.
      send_frame(8'h01, 1'b0, 1'b1, -1, 1'b0);
      sb.push_back(8'h5A);
      send_good(8'h5A);
      step(10);
      chk("pre_rst_count", 32'(count), 1);
      chk("pre_rst_error", 32'(error), 'h1);
      rx = 1'b0;
      step(CPB);
      rx = 1'b0;
      step(CPB);
      rx = 1'b1;
      step(CPB/2);
      reset = 1'b1;
      step(2);
      chk("mid_rst_data", 32'(data), 0);
      chk("mid_rst_sent", 32'(sent), 0);
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_error", 32'(error), 0);
      sb.delete();
      reset = 1'b0;
      step(20);
      sb.push_back(8'h7E);
      send_good(8'h7E);
      step(10);
      chk("post_rst_count", 32'(count), 1);
      pop_one("post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
